multi_input_conditioner: RTL

Parametrised, multi-channel successor to the single-bit input conditioner. Synchronises, debounces and edge-detects `CHANNELS` independent asynchronous inputs (buttons, switches, external strobes). It adds a configurable synchroniser depth, synchronous reset, a per-channel long-press (`held`) pulse and an aggregate change flag. It sits between board I/O pins and the control FSMs of the neural-net front end.

---
 rtl/multi_input_conditioner_pkg.sv | 12 +
 rtl/conditioner_channel.sv | 112 +++++++++++
 rtl/multi_input_conditioner.sv | 44 ++++
 3 files changed

// File: rtl/multi_input_conditioner_pkg.sv
// Shared default parameter values for the multi-channel input conditioner.
// The top level and the board pin mapping take their defaults from here.
package multi_input_conditioner_pkg;

  localparam int DEF_CHANNELS      = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_COUNTER_WIDTH = 3;
  localparam int DEF_WAIT_TIME     = 3;
  localparam int DEF_HOLD_WIDTH    = 8;
  localparam int DEF_HOLD_TIME     = 200;

endpackage

// File: rtl/conditioner_channel.sv
// Single-bit conditioner: synchroniser chain, debounce counter, edge pulses
// and an optional long-press (held) pulse.
//
// A change at the synchroniser output must persist for WAIT_TIME+1 cycles
// before the debounced level follows it. Any return to the current level
// during that window clears the count.
module conditioner_channel
  import multi_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int WAIT_TIME     = DEF_WAIT_TIME,
  parameter int HOLD_WIDTH    = DEF_HOLD_WIDTH,
  parameter int HOLD_TIME     = DEF_HOLD_TIME
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge,
  output logic held
);

  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     cond_q, cond_d;
  logic                     pos_q, pos_d;
  logic                     neg_q, neg_d;
  logic                     sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the raw input into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], noisysignal};
  end

  // Debounce: count consecutive mismatch cycles, commit the new level and
  // emit a one-cycle edge pulse when the count reaches WAIT_TIME.
  always_comb begin
    cnt_d  = cnt_q;
    cond_d = cond_q;
    pos_d  = 1'b0;
    neg_d  = 1'b0;
    if (cond_q == sync_out) begin
      cnt_d = '0;
    end else if (cnt_q == COUNTER_WIDTH'(WAIT_TIME)) begin
      cnt_d  = '0;
      cond_d = sync_out;
      pos_d  = sync_out;
      neg_d  = ~sync_out;
    end else begin
      cnt_d = cnt_q + COUNTER_WIDTH'(1);
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      cond_q <= 1'b0;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      cond_q <= cond_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
    end
  end

  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;

  if (HOLD_TIME > 0) begin : g_hold
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic                  held_q, held_d;

    // Hold counter saturates at HOLD_TIME; held fires only on the step
    // into saturation, so it cannot re-fire until the level drops.
    always_comb begin
      hold_d = hold_q;
      held_d = 1'b0;
      if (!cond_q) begin
        hold_d = '0;
      end else if (hold_q != HOLD_WIDTH'(HOLD_TIME)) begin
        hold_d = hold_q + HOLD_WIDTH'(1);
        held_d = (hold_q == HOLD_WIDTH'(HOLD_TIME - 1));
      end
    end

    // Hold counter and held pulse registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        hold_q <= '0;
        held_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        held_q <= held_d;
      end
    end

    assign held = held_q;
  end else begin : g_no_hold
    assign held = 1'b0;
  end

endmodule

// File: rtl/multi_input_conditioner.sv
// Multi-channel input conditioner: one independent conditioner_channel per
// input plus an aggregate flag that is high whenever any channel emits an
// edge pulse (combinational from the registered pulses, no extra latency).
module multi_input_conditioner
  import multi_input_conditioner_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int WAIT_TIME     = DEF_WAIT_TIME,
  parameter int HOLD_WIDTH    = DEF_HOLD_WIDTH,
  parameter int HOLD_TIME     = DEF_HOLD_TIME
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisysignal,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic [CHANNELS-1:0] held,
  output logic                anyedge
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    conditioner_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .WAIT_TIME    (WAIT_TIME),
      .HOLD_WIDTH   (HOLD_WIDTH),
      .HOLD_TIME    (HOLD_TIME)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .noisysignal (noisysignal[i]),
      .conditioned (conditioned[i]),
      .positiveedge(positiveedge[i]),
      .negativeedge(negativeedge[i]),
      .held        (held[i])
    );
  end

  assign anyedge = |(positiveedge | negativeedge);

endmodule
